// File: rtl/rr_arb4_ctrl_if.sv
// Request/grant bundle between the requesters and the 4-way round-robin arbiter.
// The arbiter connects through the slave modport; the requester side uses master.
interface rr_arb4_ctrl_if;
  logic       EN;
  logic [3:0] REQ;
  logic [3:0] GNT;
  logic       GNT_VLD;
  logic [1:0] GNT_ID;
  logic       IDLE;

  modport master (
    output EN,
    output REQ,
    input  GNT,
    input  GNT_VLD,
    input  GNT_ID,
    input  IDLE
  );

  modport slave (
    input  EN,
    input  REQ,
    output GNT,
    output GNT_VLD,
    output GNT_ID,
    output IDLE
  );
endinterface

// File: rtl/rr_arb4_ctrl.sv
// 4-requester round-robin arbiter with registered one-hot grant, break-before-make
// between owners and a bounded hold time when another requester is waiting.
module rr_arb4_ctrl #(
  parameter int unsigned HOLD_MAX = 8,
  parameter int unsigned CNT_W    = 4
) (
  input  logic                CLK,
  input  logic                RN,
  rr_arb4_ctrl_if.slave       bus
);

  localparam logic [CNT_W-1:0] HoldMax = CNT_W'(HOLD_MAX);
  localparam logic [CNT_W-1:0] CntOne  = CNT_W'(1);

  typedef enum logic [0:0] {
    StIdle,
    StGrant
  } state_e;

  state_e           state_q, state_d;
  logic [3:0]       gnt_q, gnt_d;
  logic             gnt_vld_q, gnt_vld_d;
  logic [1:0]       gnt_id_q, gnt_id_d;
  logic [1:0]       ptr_q, ptr_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic [1:0] win;
  logic       win_found;
  logic [3:0] owner_mask;
  logic       rel;

  // First requester in search order ptr, ptr+1, ptr+2, ptr+3 (mod 4).
  always_comb begin
    win       = ptr_q;
    win_found = 1'b0;
    for (int k = 0; k < 4; k++) begin
      if (!win_found && bus.REQ[ptr_q + 2'(k)]) begin
        win       = ptr_q + 2'(k);
        win_found = 1'b1;
      end
    end
  end

  // Release on owner drop, disable, or hold limit reached with a competitor waiting.
  always_comb begin
    owner_mask = 4'b0001 << gnt_id_q;
    rel        = !bus.REQ[gnt_id_q] || !bus.EN ||
                 ((cnt_q == HoldMax) && ((bus.REQ & ~owner_mask) != 4'b0000));
  end

  always_comb begin
    state_d   = state_q;
    gnt_d     = gnt_q;
    gnt_vld_d = gnt_vld_q;
    gnt_id_d  = gnt_id_q;
    ptr_d     = ptr_q;
    cnt_d     = cnt_q;
    unique case (state_q)
      StIdle: begin
        if (bus.EN && win_found) begin
          gnt_d     = 4'b0001 << win;
          gnt_vld_d = 1'b1;
          gnt_id_d  = win;
          cnt_d     = CntOne;
          state_d   = StGrant;
        end
      end
      StGrant: begin
        if (rel) begin
          gnt_d     = 4'b0000;
          gnt_vld_d = 1'b0;
          ptr_d     = gnt_id_q + 2'd1;
          cnt_d     = '0;
          state_d   = StIdle;
        end else if (cnt_q < HoldMax) begin
          cnt_d = cnt_q + CntOne;
        end
      end
      default: begin
        gnt_d     = 4'b0000;
        gnt_vld_d = 1'b0;
        cnt_d     = '0;
        state_d   = StIdle;
      end
    endcase
  end

  always_ff @(posedge CLK or negedge RN) begin
    if (!RN) begin
      state_q   <= StIdle;
      gnt_q     <= 4'b0000;
      gnt_vld_q <= 1'b0;
      gnt_id_q  <= 2'd0;
      ptr_q     <= 2'd0;
      cnt_q     <= '0;
    end else begin
      state_q   <= state_d;
      gnt_q     <= gnt_d;
      gnt_vld_q <= gnt_vld_d;
      gnt_id_q  <= gnt_id_d;
      ptr_q     <= ptr_d;
      cnt_q     <= cnt_d;
    end
  end

  assign bus.GNT     = gnt_q;
  assign bus.GNT_VLD = gnt_vld_q;
  assign bus.GNT_ID  = gnt_id_q;
  assign bus.IDLE    = ~(bus.REQ[0] | bus.REQ[1] | bus.REQ[2] | bus.REQ[3]);

endmodule
